// File: rtl/clock_pkg.sv
// Shared widths and wrap limits for the time-of-day counters.
package clock_pkg;

  localparam int HOURS_W     = 5;
  localparam int MIN_W       = 6;
  localparam int SEC_W       = 6;
  localparam int MAX_HOURS   = 23;
  localparam int MAX_MINUTES = 59;
  localparam int MAX_SECONDS = 59;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with clamped parallel load, count enable and carry-out.
module mod_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_d,
  output logic         carry
);

  logic [W-1:0] count_q;

  // Carry is combinational so the next stage advances on the same edge.
  assign carry = en && (count_q == W'(MAX));

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (load_val > W'(MAX)) ? '0 : load_val;
    end else if (en) begin
      count_d = carry ? '0 : count_q + W'(1);
    end
  end

  // NOTE: registers take <= only; the synchronous reset lives inside the clocked block.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/time_keeper.sv
// 24-hour time-of-day keeper with prescaler, load, hold and pulse outputs.
// Alarm comparator is built only when TIME_KEEPER_ALARM_EN is defined.
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLOCK_HZ = 50000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               update,
  input  logic               hold,
  input  logic [HOURS_W-1:0] setHours,
  input  logic [MIN_W-1:0]   setMinutes,
  input  logic [SEC_W-1:0]   setSeconds,
  input  logic               alarmEnable,
  input  logic [HOURS_W-1:0] alarmHours,
  input  logic [MIN_W-1:0]   alarmMinutes,
  output logic [HOURS_W-1:0] hours,
  output logic [MIN_W-1:0]   minutes,
  output logic [SEC_W-1:0]   seconds,
  output logic               tick,
  output logic               dayWrap,
  output logic               alarm
);

  localparam int PRE_W = $clog2(CLOCK_HZ);

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               advance;
  logic               sec_carry, min_carry, hr_carry;
  logic [SEC_W-1:0]   sec_d;
  logic [MIN_W-1:0]   min_d;
  logic [HOURS_W-1:0] hr_d;
  logic               tick_q, day_wrap_q, alarm_q, alarm_d;

  assign advance = (pre_q == PRE_W'(CLOCK_HZ - 1)) && !hold && !update;

  always_comb begin
    pre_d = pre_q;
    if (update) begin
      pre_d = '0;
    end else if (!hold) begin
      pre_d = (pre_q == PRE_W'(CLOCK_HZ - 1)) ? '0 : pre_q + PRE_W'(1);
    end
  end

  mod_counter #(.W(SEC_W), .MAX(MAX_SECONDS)) u_sec (
    .clock(clock), .reset(reset), .load(update), .load_val(setSeconds),
    .en(advance), .count(seconds), .count_d(sec_d), .carry(sec_carry)
  );

  mod_counter #(.W(MIN_W), .MAX(MAX_MINUTES)) u_min (
    .clock(clock), .reset(reset), .load(update), .load_val(setMinutes),
    .en(sec_carry), .count(minutes), .count_d(min_d), .carry(min_carry)
  );

  mod_counter #(.W(HOURS_W), .MAX(MAX_HOURS)) u_hr (
    .clock(clock), .reset(reset), .load(update), .load_val(setHours),
    .en(min_carry), .count(hours), .count_d(hr_d), .carry(hr_carry)
  );

`ifdef TIME_KEEPER_ALARM_EN
  // Compare against the post-advance time so the pulse lines up with tick.
  assign alarm_d = advance && alarmEnable && (sec_d == '0) &&
                   (min_d == alarmMinutes) && (hr_d == alarmHours);
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarmEnable, alarmHours, alarmMinutes, min_d, hr_d, sec_d};
  assign alarm_d      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q      <= '0;
      tick_q     <= 1'b0;
      day_wrap_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      tick_q     <= advance;
      day_wrap_q <= hr_carry;
      alarm_q    <= alarm_d;
    end
  end

  assign tick    = tick_q;
  assign dayWrap = day_wrap_q;
`ifdef TIME_KEEPER_ALARM_EN
  assign alarm   = alarm_q;
`else
  assign alarm   = 1'b0;
`endif

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter: CLOCK_HZ, default 50000000, number of clock cycles per second tick (minimum 2).
REQ-002 SHALL have ports, one per line:
 clock  input  1  system clock, all logic on rising edge
 reset  input  1  synchronous, active-high reset
 update  input  1  one-cycle load strobe from the clock control FSM
 hold  input  1  freeze counting while high (driven by the FSM set-entry flag)
 setHours  input  5  hours value to load on update
 setMinutes  input  6  minutes value to load on update
 setSeconds  input  6  seconds value to load on update
 alarmEnable  input  1  arms the alarm comparator
 alarmHours  input  5  alarm hour
 alarmMinutes  input  6  alarm minute
 hours  output  5  current hours, 0..23
 minutes  output  6  current minutes, 0..59
 seconds  output  6  current seconds, 0..59
 tick  output  1  one-cycle pulse, once per counted second
 dayWrap  output  1  one-cycle pulse on 23:59:59 -> 00:00:00
 alarm  output  1  one-cycle pulse on reaching alarm time
REQ-003 SHALL have one clock domain, clock only; reset is synchronous and active-high.

Function
REQ-004 SHALL run a prescaler counting 0..CLOCK_HZ-1 and wrapping to 0.
REQ-005 SHALL advance time by one second on the rising edge where the prescaler equals CLOCK_HZ-1, hold=0, update=0.
REQ-006 SHALL increment seconds and wrap 59->0 with carry into minutes; minutes wrap 59->0 with carry into hours; hours wrap 23->0.
REQ-007 SHALL drive tick, dayWrap and alarm as registered outputs, high for exactly the one cycle after the advancing edge.
REQ-008 SHALL assert dayWrap only on the 23:59:59 -> 00:00:00 advance.
REQ-009 SHALL, on update=1, load setHours/setMinutes/setSeconds, clear the prescaler and suppress tick/dayWrap/alarm that cycle.
REQ-010 SHALL clamp each out-of-range load field to 0 (hours>23, minutes>59, seconds>59), per field independently.
REQ-011 SHALL, while hold=1 and update=0, freeze prescaler and time and produce no pulses; counting resumes from the frozen prescaler value.
REQ-012 SHALL apply priority reset > update > hold > count; update coinciding with a prescaler wrap loads and does not increment.
REQ-013 SHALL pulse alarm when an advance (not an update) produces alarmHours:alarmMinutes:00 while alarmEnable=1.

Reset
REQ-014 SHALL, on reset=1 at a rising edge, set hours=0, minutes=0, seconds=0, prescaler=0, tick=0, dayWrap=0, alarm=0.
REQ-015 SHALL let reset abort an update or held state mid-operation with no residual pulse on the next cycle.

Configuration
REQ-016 SHALL include the alarm comparator only when macro TIME_KEEPER_ALARM_EN is defined.
REQ-017 SHALL, without TIME_KEEPER_ALARM_EN, keep all alarm ports, ignore alarmEnable/alarmHours/alarmMinutes and tie alarm to constant 0.

Structure
REQ-018 SHALL take widths (HOURS_W=5, MIN_W=6, SEC_W=6) and limits (MAX_HOURS=23, MAX_MINUTES=59, MAX_SECONDS=59) from shared package clock_pkg.
REQ-019 SHALL use one sub-module mod_counter (modulo-N counter with load, enable and carry-out), instantiated for seconds, minutes and hours.

Verification (CLOCK_HZ=4)
REQ-020 SHALL check: reset, then 8 cycles -> seconds=2, tick high on cycles 4 and 8 only.
REQ-021 SHALL check: update 23:59:58, then 8 cycles -> 23:59:59, then 00:00:00, exactly one dayWrap pulse.
REQ-022 SHALL check: update 24:60:61 -> 00:00:00; update 12:61:30 -> 12:00:30.
REQ-023 SHALL check: hold=1 for 20 cycles mid-prescale (prescaler=2) -> no change, no tick; after release, next advance exactly 2 cycles later.
REQ-024 SHALL check: update 05:10:15 on the prescaler-wrap cycle -> 05:10:15, no tick; next advance 4 cycles later to 05:10:16.
REQ-025 SHALL check: macro defined, alarm 07:30 enabled, load 07:29:59, one advance -> one alarm pulse; macro undefined -> alarm stays 0.
